// File: rtl/clkbank_pkg.sv
// Shared definitions for the clock divider bank: default field width,
// the divide-field type and the divide-field -> output-period relation.
package clkbank_pkg;

    localparam int unsigned CLKBANK_CNT_W = 8;

    typedef logic [CLKBANK_CNT_W-1:0] div_field_t;

    // Output period in input-clock cycles for divide field d: 2*(d+1).
    function automatic int unsigned clk_period(input int unsigned d);
        return 2 * (d + 1);
    endfunction

endpackage

// File: rtl/clkbank_channel.sv
// One divider channel: wrap counter, raw toggle flop, shadow ratio with
// pending flag, and the end-of-period apply point.
//
// mode     | meaning
// run      | counting 0..div_q, raw toggles on each wrap
// parked   | gate low seen at a 1->0 wrap; counter and raw held at 0
//
// A new ratio only ever lands on a 1->0 wrap, on a realign, or when leaving
// park, so every half period is built from a single ratio.
module clkbank_channel
    import clkbank_pkg::*;
#(
    parameter int unsigned      CNT_W     = CLKBANK_CNT_W,
    parameter logic [CNT_W-1:0] RESET_DIV = CNT_W'(1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             realign_i,
    input  logic             gate_en_i,
    input  logic [CNT_W-1:0] div_in_i,
    output logic             raw_o,
    output logic             pend_o,
    output logic [CNT_W-1:0] div_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             raw_q, raw_d;
    logic             pend_q, pend_d;
    logic             park_q, park_d;
    logic             wrap;
    logic [CNT_W-1:0] applied;

    assign wrap    = (cnt_q == div_q);
    // Ratio that takes effect whenever an apply point is reached.
    assign applied = pend_q ? shadow_q : div_q;

    // Next-state: realign beats counting; loads always land in the shadow.
    always_comb begin
        cnt_d    = cnt_q;
        raw_d    = raw_q;
        div_d    = div_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        park_d   = park_q;
        if (realign_i) begin
            cnt_d  = '0;
            raw_d  = 1'b0;
            pend_d = 1'b0;
            park_d = park_q & ~gate_en_i;
            if (load_i) begin
                shadow_d = div_in_i;
                div_d    = div_in_i;
            end else begin
                div_d = applied;
            end
        end else begin
            if (park_q) begin
                cnt_d = '0;
                raw_d = 1'b0;
                if (gate_en_i) begin
                    park_d = 1'b0;
                    div_d  = applied;
                    pend_d = 1'b0;
                end
            end else if (wrap) begin
                cnt_d = '0;
                raw_d = ~raw_q;
                if (raw_q) begin
                    // End of a full period: the only safe place to switch ratio.
                    div_d  = applied;
                    pend_d = 1'b0;
                    park_d = ~gate_en_i;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            // Compared with the ratio in effect after this edge, so a load
            // on an apply cycle queues behind the shadow being applied.
            if (load_i) begin
                shadow_d = div_in_i;
                pend_d   = (div_in_i != div_d);
            end
        end
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            raw_q    <= 1'b0;
            div_q    <= RESET_DIV;
            shadow_q <= RESET_DIV;
            pend_q   <= 1'b0;
            park_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            raw_q    <= raw_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            park_q   <= park_d;
        end
    end

    assign raw_o  = raw_q;
    assign pend_o = pend_q;
    assign div_o  = div_q;

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel clock divider bank. Fans load/realign out to NUM_CH
// channels and applies the static output inversion to the registered
// raw outputs. Optional per-channel parking is enabled by defining
// CLKBANK_GATE_EN, which adds the gate_en port; without it all channels
// always run.
module clock_divider_bank
    import clkbank_pkg::*;
#(
    parameter int unsigned               NUM_CH    = 4,
    parameter int unsigned               CNT_W     = CLKBANK_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]   RESET_DIV = {NUM_CH{CNT_W'(1)}},
    parameter logic [NUM_CH-1:0]         INV_MASK  = NUM_CH'(4'b0011)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic                    load,
    input  logic                    realign,
`ifdef CLKBANK_GATE_EN
    input  logic [NUM_CH-1:0]       gate_en,
`endif
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH*CNT_W-1:0] div_cur
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] gate_run;

`ifdef CLKBANK_GATE_EN
    assign gate_run = gate_en;
`else
    assign gate_run = '1;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkbank_channel #(
            .CNT_W     (CNT_W),
            .RESET_DIV (RESET_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk_i     (clock),
            .rst_ni    (reset),
            .load_i    (load),
            .realign_i (realign),
            .gate_en_i (gate_run[i]),
            .div_in_i  (div_in[i*CNT_W +: CNT_W]),
            .raw_o     (raw[i]),
            .pend_o    (pending[i]),
            .div_o     (div_cur[i*CNT_W +: CNT_W])
        );
    end

    // Raw outputs are flop outputs; inversion is a constant mask on them.
    assign clk_out = raw ^ INV_MASK;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank with default parameters.
module tb_clock_divider_bank;
    import clkbank_pkg::*;

    localparam logic [3:0] INV = 4'b0011;

    typedef struct {
        string name;
        int    hi;
        int    lo;
    } exp_t;

    logic        clock   = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] div_in  = 32'h0101_0101;
    logic        load    = 1'b0;
    logic        realign = 1'b0;
    wire  [3:0]  clk_out;
    wire  [3:0]  pending;
    wire  [31:0] div_cur;
`ifdef CLKBANK_GATE_EN
    logic [3:0]  gate_en = 4'hF;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   d3_now  = 1;
    exp_t exp_q[$];

    clock_divider_bank dut (
        .clock   (clock),
        .reset   (reset),
        .div_in  (div_in),
        .load    (load),
        .realign (realign),
`ifdef CLKBANK_GATE_EN
        .gate_en (gate_en),
`endif
        .clk_out (clk_out),
        .pending (pending),
        .div_cur (div_cur)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pack4(input int d0, input int d1, input int d2, input int d3);
        return {div_field_t'(d3), div_field_t'(d2), div_field_t'(d1), div_field_t'(d0)};
    endfunction

    function automatic bit rawb(input int ch);
        return clk_out[ch] ^ INV[ch];
    endfunction

    task automatic push_exp(input string n, input int d);
        exp_t e;
        e.name = n;
        e.hi   = int'(clk_period(d)) / 2;
        e.lo   = int'(clk_period(d)) / 2;
        exp_q.push_back(e);
    endtask

    task automatic wait_edge(input int ch, input bit level, input string tag);
        bit prev;
        int budget;
        prev   = rawb(ch);
        budget = 600;
        forever begin
            @(negedge clock);
            if (rawb(ch) == level && prev != level) return;
            prev = rawb(ch);
            budget--;
            if (budget == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: no edge on ch%0d within budget, wanted level %0d", tag, ch, level);
                return;
            end
        end
    endtask

    task automatic measure(input int ch, output int hi, output int lo, output bit ok);
        int budget;
        bit prev;
        hi = 0; lo = 0; ok = 1'b0;
        budget = 1500;
        prev = rawb(ch);
        while (budget > 0) begin
            @(negedge clock);
            budget--;
            if (rawb(ch) && !prev) break;
            prev = rawb(ch);
        end
        if (budget == 0) return;
        hi = 1;
        while (budget > 0) begin
            @(negedge clock);
            budget--;
            if (rawb(ch)) hi++;
            else break;
        end
        lo = 1;
        while (budget > 0) begin
            @(negedge clock);
            budget--;
            if (!rawb(ch)) lo++;
            else begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_pending_clear(input logic [3:0] mask, input string tag, output int waited);
        waited = 0;
        while ((pending & mask) != 4'b0 && waited < 1200) begin
            @(negedge clock);
            waited++;
        end
        if ((pending & mask) != 4'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: pending=%b still set after %0d cycles", tag, pending, waited);
        end
    endtask

    task automatic test_reset();
        int hi, lo, bad;
        bit ok;
        exp_t e;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++;
        if (clk_out !== 4'b0011) begin
            n_fail++; $display("FAIL reset_clk_out: got %b want %b", clk_out, 4'b0011);
        end
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pending: got %b want 0000", pending);
        end
        n_tests++;
        if (div_cur !== pack4(1, 1, 1, 1)) begin
            n_fail++; $display("FAIL reset_div_cur: got %h want %h", div_cur, pack4(1, 1, 1, 1));
        end
        reset = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            push_exp($sformatf("reset_period_ch%0d", ch), 1);
            measure(ch, hi, lo, ok);
            e = exp_q.pop_front();
            n_tests++;
            if (!ok || hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
            end
        end
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            if (clk_out[0] !== ~clk_out[2] || clk_out[1] !== ~clk_out[3]) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL reset_inverted_copies: %0d bad cycles, want 0", bad);
        end
        n_tests++;
        if (pending !== 4'b0000) begin
            n_fail++; $display("FAIL reset_pending_after: got %b want 0000", pending);
        end
    endtask

    task automatic test_load_mid_high();
        int hi, lo, waited;
        bit ok;
        exp_t e;
        wait_edge(2, 1'b1, "load_mid_high_rise");
        div_in = pack4(1, 1, 3, 1);
        load   = 1'b1;
        push_exp("ch2_div3_period", 3);
        @(negedge clock);
        load = 1'b0;
        n_tests++;
        if (pending !== 4'b0100 || rawb(2) !== 1'b1) begin
            n_fail++; $display("FAIL ch2_pending_set: pending=%b raw2=%0d, want 0100 raw2=1", pending, rawb(2));
        end
        wait_pending_clear(4'b0100, "ch2_apply", waited);
        n_tests++;
        if (waited !== 1 || rawb(2) !== 1'b0 || div_cur[23:16] !== 8'd3) begin
            n_fail++;
            $display("FAIL ch2_apply_point: waited=%0d raw2=%0d div=%0d, want 1 0 3", waited, rawb(2), div_cur[23:16]);
        end
        measure(2, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
    endtask

    task automatic test_double_load();
        int hi, lo, waited;
        bit ok;
        exp_t e;
        wait_edge(1, 1'b0, "double_load_fall");
        div_in = pack4(1, 5, 3, 1);
        load   = 1'b1;
        @(negedge clock);
        n_tests++;
        if (pending !== 4'b0010) begin
            n_fail++; $display("FAIL ch1_first_load: pending=%b want 0010", pending);
        end
        div_in = pack4(1, 0, 3, 1);
        push_exp("ch1_last_wins", 0);
        @(negedge clock);
        load = 1'b0;
        n_tests++;
        if (pending[1] !== 1'b1 || div_cur[15:8] !== 8'd1) begin
            n_fail++; $display("FAIL ch1_still_pending: pending=%b div=%0d, want bit1=1 div=1", pending, div_cur[15:8]);
        end
        wait_pending_clear(4'b0010, "ch1_apply", waited);
        n_tests++;
        if (div_cur[15:8] !== 8'd0 || rawb(1) !== 1'b0) begin
            n_fail++; $display("FAIL ch1_applied: div=%0d raw1=%0d, want 0 0", div_cur[15:8], rawb(1));
        end
        measure(1, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
    endtask

    task automatic test_program_realign();
        int hi, lo, waited, bad;
        bit ok, want;
        exp_t e;
        @(negedge clock);
        div_in = pack4(0, 0, 3, 2);
        load   = 1'b1;
        push_exp("ch0_div0_period", 0);
        push_exp("ch3_div2_period", 2);
        @(negedge clock);
        load = 1'b0;
        wait_pending_clear(4'b1111, "program_apply", waited);
        measure(0, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
        measure(3, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
        // Pending shadows are applied by realign.
        div_in = pack4(2, 1, 1, 1);
        load   = 1'b1;
        @(negedge clock);
        load    = 1'b0;
        realign = 1'b1;
        @(negedge clock);
        realign = 1'b0;
        n_tests++;
        if (clk_out !== INV || pending !== 4'b0000 || div_cur !== pack4(2, 1, 1, 1)) begin
            n_fail++;
            $display("FAIL realign_applies_pending: clk_out=%b pending=%b div=%h, want %b 0000 %h", clk_out, pending, div_cur, INV, pack4(2, 1, 1, 1));
        end
        // Load and realign together: applied at once.
        repeat (3) @(negedge clock);
        div_in  = pack4(1, 1, 1, 1);
        load    = 1'b1;
        realign = 1'b1;
        @(negedge clock);
        load    = 1'b0;
        realign = 1'b0;
        n_tests++;
        if (clk_out !== INV || pending !== 4'b0000 || div_cur !== pack4(1, 1, 1, 1)) begin
            n_fail++;
            $display("FAIL load_with_realign: clk_out=%b pending=%b div=%h, want %b 0000 %h", clk_out, pending, div_cur, INV, pack4(1, 1, 1, 1));
        end
        repeat ($urandom_range(1, 7)) @(negedge clock);
        realign = 1'b1;
        @(negedge clock);
        realign = 1'b0;
        n_tests++;
        if (clk_out !== INV) begin
            n_fail++; $display("FAIL realign_raw_zero: clk_out=%b want %b", clk_out, INV);
        end
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            want = ((k / 2) % 2) == 1;
            if (rawb(2) != want || rawb(3) != rawb(2) || rawb(0) != rawb(2) || rawb(1) != rawb(2)) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL realign_phase_identical: %0d bad cycles, want 0", bad);
        end
    endtask

`ifdef CLKBANK_GATE_EN
    task automatic test_gate();
        int hi, lo, bad;
        bit ok;
        exp_t e;
        wait_edge(3, 1'b1, "gate_rise");
        gate_en[3] = 1'b0;
        wait_edge(3, 1'b0, "gate_fall");
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rawb(3) !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL gate_parked_low: %0d high cycles while parked, want 0", bad);
        end
        div_in = pack4(1, 1, 1, 2);
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        n_tests++;
        if (pending !== 4'b1000 || div_cur[31:24] !== 8'd1) begin
            n_fail++; $display("FAIL gate_load_parked: pending=%b div3=%0d, want 1000 1", pending, div_cur[31:24]);
        end
        repeat (3) @(negedge clock);
        gate_en[3] = 1'b1;
        push_exp("ch3_reenable", 2);
        @(negedge clock);
        d3_now = 2;
        n_tests++;
        if (pending !== 4'b0000 || div_cur[31:24] !== 8'd2 || rawb(3) !== 1'b0) begin
            n_fail++; $display("FAIL gate_reenable_apply: pending=%b div3=%0d raw3=%0d, want 0000 2 0", pending, div_cur[31:24], rawb(3));
        end
        measure(3, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
    endtask
`endif

    task automatic test_max_div();
        int hi, lo, waited;
        bit ok;
        exp_t e;
        @(negedge clock);
        div_in = pack4(1, 255, 1, d3_now);
        load   = 1'b1;
        push_exp("ch1_max_field", 255);
        @(negedge clock);
        load = 1'b0;
        wait_pending_clear(4'b1111, "max_apply", waited);
        n_tests++;
        if (div_cur !== pack4(1, 255, 1, d3_now)) begin
            n_fail++; $display("FAIL max_div_cur: got %h want %h", div_cur, pack4(1, 255, 1, d3_now));
        end
        measure(1, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo) begin
            n_fail++; $display("FAIL %s: hi=%0d lo=%0d ok=%0d, want hi=%0d lo=%0d", e.name, hi, lo, ok, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid();
        int hi, lo;
        bit ok;
        exp_t e;
        wait_edge(0, 1'b1, "reset_mid_rise");
        div_in = pack4(4, 255, 1, d3_now);
        load   = 1'b1;
        @(negedge clock);
        load = 1'b0;
        n_tests++;
        if (pending !== 4'b0001 || rawb(0) !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_setup: pending=%b raw0=%0d, want 0001 1", pending, rawb(0));
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if (clk_out !== INV || pending !== 4'b0000 || div_cur !== pack4(1, 1, 1, 1)) begin
            n_fail++;
            $display("FAIL reset_mid_async: clk_out=%b pending=%b div=%h, want %b 0000 %h", clk_out, pending, div_cur, INV, pack4(1, 1, 1, 1));
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        push_exp("ch0_shadow_discarded", 1);
        measure(0, hi, lo, ok);
        e = exp_q.pop_front();
        n_tests++;
        if (!ok || hi !== e.hi || lo !== e.lo || pending !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s: hi=%0d lo=%0d ok=%0d pending=%b, want hi=%0d lo=%0d pending=0000", e.name, hi, lo, ok, pending, e.hi, e.lo);
        end
    endtask

    initial begin
        test_reset();
        test_load_mid_high();
        test_double_load();
        test_program_realign();
`ifdef CLKBANK_GATE_EN
        test_gate();
`endif
        test_max_div();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised multi-channel clock divider that generates the processor, regfile, imem and dmem clocks from one input clock.
- Successor to the fixed divide-by-2/divide-by-4 dividers.
- Per channel: runtime-programmable divide ratio, static output inversion, glitch-free ratio change, and a bank-wide synchronous phase re-alignment.
- Sits at top level between the board clock and the memory/processor/regfile clock inputs.

Parameters:
NUM_CH, 4, number of output clock channels
CNT_W, 8, width of each channel's divide field and counter
RESET_DIV, {NUM_CH{8'd1}}, packed per-channel divide field loaded at reset (1 = divide-by-4)
INV_MASK, 4'b0011, per-channel static inversion of clk_out (bit i inverts channel i)

Ports:
clock  in  1  master input clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
div_in  in  NUM_CH*CNT_W  packed new divide fields; channel i at bits [i*CNT_W +: CNT_W]
load  in  1  one-cycle strobe: capture div_in into the shadow registers
realign  in  1  one-cycle strobe: restart all channels in phase
clk_out  out  NUM_CH  divided clocks, after INV_MASK
pending  out  NUM_CH  bit i = 1 while channel i holds an unapplied shadow ratio
div_cur  out  NUM_CH*CNT_W  divide fields currently in effect

Behaviour:
- Interface fixed: one clock, `clock`; reset `reset` is asynchronous and active-low.
- Reset (reset = 0), asynchronously:
  - counters = 0; raw divided outputs = 0, so clk_out = INV_MASK
  - div_cur = shadow = RESET_DIV; pending = 0
- Divide rule:
  - Field D gives output period 2*(D+1) input cycles at 50% duty.
  - D = 0 gives /2; D = 1 gives /4.
  - Counter counts 0..D; on the wrap cycle (count == D) the raw output toggles and the counter returns to 0.
- Outputs: clk_out is registered raw output XOR INV_MASK; it is never combinationally derived from `clock`.
- Load:
  - On a load cycle, shadow <= div_in; pending bit i sets if the new field differs from div_cur[i], else stays 0.
  - A new load while pending overwrites the shadow; the last value wins.
- Apply point (glitch-free):
  - A pending shadow is copied into div_cur[i] only on a wrap cycle where the raw output goes 1 -> 0, i.e. at the end of a full period.
  - The same cycle clears pending[i] and restarts the counter at 0.
  - No half-period ever uses mixed ratios; no runt pulse is possible.
- Realign:
  - All counters <= 0 and raw outputs <= 0 on the next edge.
  - Any pending shadows are applied immediately; pending <= 0.
  - Channels with equal D are then phase-identical.
- Simultaneous events:
  - load with realign: the shadow takes div_in and is applied at once.
  - load on an apply cycle: the new div_in goes to the shadow and stays pending; the old shadow is the one applied.
- Reset mid-period:
  - Outputs return immediately to INV_MASK.
  - The shadow is discarded.
- Maximum field D = 2^CNT_W - 1, with no overflow; the counter compare is equality on CNT_W bits.

Optional Feature:
- Macro: CLKBANK_GATE_EN.
- With the macro defined:
  - Add port gate_en in NUM_CH; a low bit parks that channel.
  - A parked channel stops at its next 1 -> 0 raw transition, holds raw 0, and keeps its counter at 0.
  - Re-enabling starts a fresh full period from count 0.
  - Loads still update the shadow; the shadow is applied on re-enable.
- Without the macro: the port is absent and all channels always run.

Decomposition:
- Package clkbank_pkg:
  - CNT_W default.
  - The divide-field typedef.
  - The function computing period = 2*(D+1), used by the bench.
- Sub-module clkbank_channel:
  - Holds one counter, raw toggle flop, shadow, pending flag and apply logic.
  - Instantiated NUM_CH times in a generate loop.
  - The top holds only the load/realign fan-out and output inversion.

Test Plan:
- Reset release with defaults (RESET_DIV all 1, INV_MASK 4'b0011) -> clk_out = 4'b0011 during reset; afterwards every channel has period 4 input cycles, channels 0/1 are inverted copies of 2/3, and pending = 0.
- load with div_in ch2 = 3 mid-high-phase -> ch2 finishes its /4 period; pending[2] = 1 until the 1 -> 0 edge, then period 8 with high time exactly 4 cycles and no short pulse.
- Two loads before the apply point (ch1 = 5, then ch1 = 0) -> only D = 0 is applied; ch1 runs /2; pending[1] clears at the apply cycle.
- Program ch0 = 0 and ch3 = 2 -> both channels run at their new ratios. Then set all D = 1 and pulse realign at an arbitrary cycle -> on the next edge all raw outputs are 0; thereafter ch2 and ch3 toggle on identical cycles.
- Assert reset = 0 mid-period with pending[0] = 1 -> clk_out = INV_MASK immediately, pending = 0, div_cur = RESET_DIV.
- With CLKBANK_GATE_EN, drop gate_en[3] while raw is high -> ch3 holds 0 from its next falling transition; re-raise -> first high phase is a full D+1 cycles.
